seq_detector: RTL and testbench

Parametrised serial bit-pattern detector: the generalised successor to the fixed 3-bit Mealy detectors in the FSM library. It compares a 1-bit input stream against a compile-time pattern of arbitrary length. A runtime input selects overlapping or non-overlapping detection. Each match produces a one-cycle registered pulse, and a saturating match counter is optional. It sits directly behind a serial input synchroniser and feeds framing and sync-word logic.

---
 rtl/seq_detector_pkg.sv | 67 ++++++
 rtl/seq_detector_if.sv | 44 ++++
 rtl/seq_detector_table.sv | 47 ++++
 rtl/seq_detector.sv | 99 +++++++++
 tb/tb_seq_detector.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detector_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial pattern detector:
//   MODE_NONOVERLAP / MODE_OVERLAP : values of the runtime overlap select
//   seq_det_state_w(len)           : width of the matched-prefix state
//   seq_det_next(pattern,len,k,b)  : KMP next prefix length (len == full match)
//   seq_det_fail(pattern,len)      : longest proper prefix that is also a suffix
// The functions only run at elaboration to build the transition table.
// Pattern bit order: pattern[len-1] is the first bit expected on the wire.
// -----------------------------------------------------------------------------
package seq_det_pkg;

  localparam logic MODE_NONOVERLAP = 1'b0;
  localparam logic MODE_OVERLAP    = 1'b1;
  localparam int   MAX_LEN         = 16;

  function automatic int seq_det_state_w(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction

  // Next prefix length after consuming bit b from prefix length k.
  // Builds the string prefix_k . b (s[0] is the oldest bit) and returns the
  // longest m such that its last m bits equal the first m pattern bits.
  function automatic int seq_det_next(input logic [MAX_LEN-1:0] pattern,
                                      input int len, input int k, input logic b);
    logic [MAX_LEN:0] s;
    int               n;
    int               best;
    logic             ok;
    s    = '0;
    n    = k + 1;
    best = 0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < k) s[i] = pattern[len-1-i];
    end
    s[k] = b;
    for (int m = 1; m <= MAX_LEN; m++) begin
      if (m <= n && m <= len) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < m && s[n-m+j] != pattern[len-1-j]) ok = 1'b0;
        end
        if (ok) best = m;
      end
    end
    return best;
  endfunction

  // Restart point after a full match in overlapping mode.
  function automatic int seq_det_fail(input logic [MAX_LEN-1:0] pattern,
                                      input int len);
    int   best;
    logic ok;
    best = 0;
    for (int m = 1; m < MAX_LEN; m++) begin
      if (m < len) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < m && pattern[len-1-j] != pattern[m-1-j]) ok = 1'b0;
        end
        if (ok) best = m;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detector_if.sv
// -----------------------------------------------------------------------------
// seq_detector_if
// Signal bundle between the stream source and the detector.
//   en      : sample enable (signal consumed only when 1)
//   clear   : synchronous clear of state, out and count (beats en)
//   signal  : serial data bit
//   overlap : 1 = overlapping detection, 0 = non-overlapping
//   out     : registered one-cycle match pulse
//   state   : matched-prefix length (debug)
//   count   : saturating match count (only with SEQ_DETECTOR_COUNT_EN)
// Handshake: no valid/ready; a bit is transferred on every rising clock edge
// where en=1 and clear=0, with no backpressure.
// Modports: master = stream source, slave = detector.
// -----------------------------------------------------------------------------
interface seq_detector_if
  import seq_det_pkg::*;
#(
  parameter int LEN   = 3,
  parameter int CNT_W = 8
);
  localparam int SW = seq_det_state_w(LEN);

  logic          en;
  logic          clear;
  logic          signal;
  logic          overlap;
  logic          out;
  logic [SW-1:0] state;

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] count;

  modport master (output en, clear, signal, overlap, input out, state, count);
  modport slave  (input en, clear, signal, overlap, output out, state, count);
`else
  // CNT_W only shapes the counter; kept so both builds share one parameter set.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end

  modport master (output en, clear, signal, overlap, input out, state);
  modport slave  (input en, clear, signal, overlap, output out, state);
`endif

endinterface

// File: rtl/seq_detector_table.sv
// -----------------------------------------------------------------------------
// seq_det_table
// Combinational KMP transition table for a fixed pattern.
//   k_i     : current matched-prefix length
//   bit_i   : incoming serial bit
//   nxt_o   : next prefix length when this bit does not complete the pattern
//   match_o : 1 when k_i == LEN-1 and bit_i == PATTERN[0]
// Every entry is an elaboration-time constant; rows past LEN-1 are
// unreachable and tied to zero.
// -----------------------------------------------------------------------------
module seq_det_table
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b101
) (
  input  logic [seq_det_state_w(LEN)-1:0] k_i,
  input  logic                            bit_i,
  output logic [seq_det_state_w(LEN)-1:0] nxt_o,
  output logic                            match_o
);
  localparam int SW   = seq_det_state_w(LEN);
  localparam int ROWS = 2 ** SW;

  logic [SW-1:0] nxt_tbl   [ROWS][2];
  logic          match_tbl [ROWS][2];

  for (genvar gk = 0; gk < ROWS; gk++) begin : g_k
    for (genvar gb = 0; gb < 2; gb++) begin : g_b
      if (gk < LEN) begin : g_live
        localparam int NXT = seq_det_next(16'(PATTERN), LEN, gk, 1'(gb));
        localparam logic M = (NXT == LEN);
        // A full match leaves the restart decision to the top level.
        localparam logic [SW-1:0] N = M ? '0 : SW'(NXT);
        assign nxt_tbl[gk][gb]   = N;
        assign match_tbl[gk][gb] = M;
      end else begin : g_dead
        assign nxt_tbl[gk][gb]   = '0;
        assign match_tbl[gk][gb] = 1'b0;
      end
    end
  end

  assign nxt_o   = nxt_tbl[k_i][bit_i];
  assign match_o = match_tbl[k_i][bit_i];

endmodule

// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
// Serial bit-pattern detector for a compile-time pattern of LEN bits
// (PATTERN[LEN-1] arrives first) with runtime overlap select.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : seq_detector_if slave (en, clear, signal, overlap -> out, state[, count])
// A match raises out for one cycle after the edge that sampled the last bit.
// Optional feature macro: SEQ_DETECTOR_COUNT_EN adds a CNT_W-bit saturating
// match counter on bus.count; without it no counter logic exists.
// -----------------------------------------------------------------------------
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b101,
  parameter int             CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_detector_if.slave bus
);
  localparam int SW = seq_det_state_w(LEN);
  // Prefix length kept after a match when overlapping.
  localparam logic [SW-1:0] RESTART_K = SW'(seq_det_fail(16'(PATTERN), LEN));

  logic [SW-1:0] state_q, state_d;
  logic          out_q, out_d;
  logic [SW-1:0] tbl_nxt;
  logic          tbl_match;

  seq_det_table #(
    .LEN     (LEN),
    .PATTERN (PATTERN)
  ) u_table (
    .k_i     (state_q),
    .bit_i   (bus.signal),
    .nxt_o   (tbl_nxt),
    .match_o (tbl_match)
  );

  // clear beats en; overlap only matters on the matching edge.
  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    if (bus.clear) begin
      state_d = '0;
    end else if (bus.en) begin
      if (tbl_match) begin
        out_d = 1'b1;
        case (bus.overlap)
          MODE_OVERLAP:    state_d = RESTART_K;
          MODE_NONOVERLAP: state_d = '0;
          default:         state_d = '0;
        endcase
      end else begin
        state_d = tbl_nxt;
      end
    end
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.en && tbl_match && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign bus.count = count_q;
`else
  // CNT_W only shapes the counter; kept so both builds share one parameter set.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_detector
// Drives five detector configurations from one shared stimulus stream and
// compares every output after every edge against a history-based model:
// the model keeps the bits consumed since the last restart and asks whether
// they end with the pattern, rather than walking a transition table.
// Configs: 0: 101/CNT8  1: 1101/CNT2  2: 111/CNT3  3: 101/CNT2  4: 11011/CNT4
// -----------------------------------------------------------------------------
module tb_seq_detector;
  import seq_det_pkg::*;

  localparam int N = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic en_r, clear_r, sig_r, ovl_r;

  seq_detector_if #(.LEN(3), .CNT_W(8)) if0 ();
  seq_detector_if #(.LEN(4), .CNT_W(2)) if1 ();
  seq_detector_if #(.LEN(3), .CNT_W(3)) if2 ();
  seq_detector_if #(.LEN(3), .CNT_W(2)) if3 ();
  seq_detector_if #(.LEN(5), .CNT_W(4)) if4 ();

  assign if0.en = en_r; assign if0.clear = clear_r; assign if0.signal = sig_r; assign if0.overlap = ovl_r;
  assign if1.en = en_r; assign if1.clear = clear_r; assign if1.signal = sig_r; assign if1.overlap = ovl_r;
  assign if2.en = en_r; assign if2.clear = clear_r; assign if2.signal = sig_r; assign if2.overlap = ovl_r;
  assign if3.en = en_r; assign if3.clear = clear_r; assign if3.signal = sig_r; assign if3.overlap = ovl_r;
  assign if4.en = en_r; assign if4.clear = clear_r; assign if4.signal = sig_r; assign if4.overlap = ovl_r;

  seq_detector #(.LEN(3), .PATTERN(3'b101),   .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  seq_detector #(.LEN(4), .PATTERN(4'b1101),  .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_detector #(.LEN(3), .PATTERN(3'b111),   .CNT_W(3)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  seq_detector #(.LEN(3), .PATTERN(3'b101),   .CNT_W(2)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  seq_detector #(.LEN(5), .PATTERN(5'b11011), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  logic        obs_out   [N];
  logic [31:0] obs_state [N];
  assign obs_out[0] = if0.out; assign obs_state[0] = 32'(if0.state);
  assign obs_out[1] = if1.out; assign obs_state[1] = 32'(if1.state);
  assign obs_out[2] = if2.out; assign obs_state[2] = 32'(if2.state);
  assign obs_out[3] = if3.out; assign obs_state[3] = 32'(if3.state);
  assign obs_out[4] = if4.out; assign obs_state[4] = 32'(if4.state);
`ifdef SEQ_DETECTOR_COUNT_EN
  logic [31:0] obs_cnt [N];
  assign obs_cnt[0] = 32'(if0.count);
  assign obs_cnt[1] = 32'(if1.count);
  assign obs_cnt[2] = 32'(if2.count);
  assign obs_cnt[3] = 32'(if3.count);
  assign obs_cnt[4] = 32'(if4.count);
`endif

  // ---------------- reference model ----------------
  int          m_len  [N] = '{3, 4, 3, 3, 5};
  logic [15:0] m_pat  [N] = '{16'b101, 16'b1101, 16'b111, 16'b101, 16'b11011};
  int          m_cntw [N] = '{8, 2, 3, 2, 4};

  bit          hist    [N][$];   // bits consumed since last restart, oldest first
  bit          exp_out [N];
  int unsigned exp_cnt [N];
  int          pulses  [N];

  int checks = 0;
  int errors = 0;

  // Last m consumed bits equal the first m bits on the wire of the pattern.
  function automatic bit hist_ends_with(input int i, input int m);
    int sz;
    sz = hist[i].size();
    if (m > sz) return 1'b0;
    for (int j = 0; j < m; j++) begin
      if (hist[i][sz-m+j] != m_pat[i][m_len[i]-1-j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int model_state(input int i);
    for (int m = m_len[i] - 1; m >= 1; m--) begin
      if (hist_ends_with(i, m)) return m;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hist[i].delete();
      exp_out[i] = 1'b0;
      exp_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (clear_r) begin
        hist[i].delete();
        exp_out[i] = 1'b0;
        exp_cnt[i] = 0;
      end else if (en_r) begin
        hist[i].push_back(sig_r);
        if (hist_ends_with(i, m_len[i])) begin
          exp_out[i] = 1'b1;
          if (exp_cnt[i] < (32'd1 << m_cntw[i]) - 1) exp_cnt[i]++;
          if (ovl_r == MODE_NONOVERLAP) hist[i].delete();
        end else begin
          exp_out[i] = 1'b0;
        end
        while (hist[i].size() > m_len[i] - 1) void'(hist[i].pop_front());
      end else begin
        exp_out[i] = 1'b0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string phase);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s d%0d out", phase, i), 32'(obs_out[i]), 32'(exp_out[i]));
      chk($sformatf("%s d%0d state", phase, i), obs_state[i], 32'(model_state(i)));
`ifdef SEQ_DETECTOR_COUNT_EN
      chk($sformatf("%s d%0d count", phase, i), obs_cnt[i], exp_cnt[i]);
`endif
      if (obs_out[i] === 1'b1) pulses[i]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string phase, input logic e, input logic c,
                      input logic s, input logic o);
    en_r = e; clear_r = c; sig_r = s; ovl_r = o;
    @(posedge clk);
    model_edge();
    #1;
    check_all(phase);
  endtask

  task automatic do_reset(input string phase);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({phase, " async"});
    @(posedge clk);
    #1;
    check_all({phase, " held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_tally();
    for (int i = 0; i < N; i++) pulses[i] = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0; en_r = 1'b0; clear_r = 1'b0; sig_r = 1'b0; ovl_r = 1'b1;
    #2;
    do_reset("init");

    // 1,0,1,0,1 overlapping: pulses after bits 3 and 5
    step("clr", 1, 1, 0, 1);
    step("ovl b1", 1, 0, 1, 1);
    step("ovl b2", 1, 0, 0, 1);
    step("ovl b3", 1, 0, 1, 1);
    chk("ovl pulse3", 32'(if0.out), 32'd1);
    step("ovl b4", 1, 0, 0, 1);
    chk("ovl gap4", 32'(if0.out), 32'd0);
    step("ovl b5", 1, 0, 1, 1);
    chk("ovl pulse5", 32'(if0.out), 32'd1);
`ifdef SEQ_DETECTOR_COUNT_EN
    chk("ovl count", 32'(if0.count), 32'd2);
`endif

    // same stream non-overlapping: one pulse only
    step("clr", 1, 1, 0, 0);
    step("non b1", 1, 0, 1, 0);
    step("non b2", 1, 0, 0, 0);
    step("non b3", 1, 0, 1, 0);
    chk("non pulse3", 32'(if0.out), 32'd1);
    step("non b4", 1, 0, 0, 0);
    step("non b5", 1, 0, 1, 0);
    chk("non nopulse5", 32'(if0.out), 32'd0);
`ifdef SEQ_DETECTOR_COUNT_EN
    chk("non count", 32'(if0.count), 32'd1);
`endif

    // 1101 with restart at f=1: pulses after bits 4 and 7
    step("clr", 1, 1, 0, 1);
    begin
      logic [6:0] s1101;
      s1101 = 7'b1101101;
      for (int b = 6; b >= 0; b--) begin
        step("p1101", 1, 0, s1101[b], 1);
        if (b == 3) chk("p1101 pulse4", 32'(if1.out), 32'd1);
        if (b == 0) chk("p1101 pulse7", 32'(if1.out), 32'd1);
      end
    end

    // reset mid-pattern discards progress
    step("clr", 1, 1, 0, 1);
    step("rstmid b1", 1, 0, 1, 1);
    step("rstmid b2", 1, 0, 0, 1);
    do_reset("rstmid");
    step("rstmid b3", 1, 0, 1, 1);
    chk("rstmid out", 32'(if0.out), 32'd0);
    chk("rstmid state", 32'(if0.state), 32'd1);

    // en=0 holds partial progress
    step("clr", 1, 1, 0, 1);
    step("hold b1", 1, 0, 1, 1);
    step("hold b2", 1, 0, 0, 1);
    for (int c = 0; c < 3; c++) step("hold idle", 0, 0, $urandom_range(0, 1), 1);
    step("hold b3", 1, 0, 1, 1);
    chk("hold pulse", 32'(if0.out), 32'd1);

    // clear on the matching edge wins
    step("clr", 1, 1, 0, 1);
    step("clrwin b1", 1, 0, 1, 1);
    step("clrwin b2", 1, 0, 0, 1);
    step("clrwin b3", 1, 1, 1, 1);
    chk("clrwin out", 32'(if0.out), 32'd0);
    chk("clrwin state", 32'(if0.state), 32'd0);

    // CNT_W=2 saturation: five matches, count stops at 3
    step("clr", 1, 1, 0, 1);
    clear_tally();
    step("sat", 1, 0, 1, 1);
    for (int r = 0; r < 5; r++) begin
      step("sat", 1, 0, 0, 1);
      step("sat", 1, 0, 1, 1);
    end
    chk("sat pulses", 32'(pulses[3]), 32'd5);
`ifdef SEQ_DETECTOR_COUNT_EN
    chk("sat count", 32'(if3.count), 32'd3);
`endif
    step("sat clr", 1, 1, 1, 1);
`ifdef SEQ_DETECTOR_COUNT_EN
    chk("sat clr count", 32'(if3.count), 32'd0);
`endif
    chk("sat clr state", 32'(if3.state), 32'd0);

    // all-ones: six 1s give four consecutive pulses
    clear_tally();
    for (int b = 1; b <= 6; b++) begin
      step("ones", 1, 0, 1, 1);
      if (b >= 3) chk($sformatf("ones b%0d", b), 32'(if2.out), 32'd1);
    end
    chk("ones pulses", 32'(pulses[2]), 32'd4);

    // randomized stream, bias toward 1s so longer patterns still hit
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rnd");
      step("rnd", ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
